// File: rtl/divider_control_unit.sv
// Control FSM for the 8-bit non-restoring divider: load, SHIFT/OP iteration pairs,
// remainder correction and a one-cycle valid pulse. Optional macro: DIVCTRL_DIVZERO_EN.
module divider_control_unit #(
    parameter int unsigned ITERATIONS = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] divisor,
    input  logic       sign_r,
    output logic       load,
    output logic       shift_en,
    output logic       add_en,
    output logic       sub_en,
    output logic       final_add,
    output logic       count_en,
    output logic       busy,
    output logic       valid,
    output logic       div_zero
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, OP, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             in_op;
    logic             in_fix;
    logic             divz;
    logic             divisor_zero;

`ifdef DIVCTRL_DIVZERO_EN
    assign divisor_zero = (divisor == '0);
`else
    logic divisor_unused;
    assign divisor_unused = ^divisor;
    assign divisor_zero   = 1'b0;
`endif

    // Flags are registered from the next state; only the sign-dependent
    // strobes below combine a registered phase flag with sign_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            divz     <= 1'b0;
            load     <= 1'b0;
            shift_en <= 1'b0;
            count_en <= 1'b0;
            in_op    <= 1'b0;
            in_fix   <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            load     <= 1'b0;
            shift_en <= 1'b0;
            count_en <= 1'b0;
            in_op    <= 1'b0;
            in_fix   <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        divz <= divisor_zero;
                        if (divisor_zero) begin
                            state <= DONE;
                            valid <= 1'b1;
                        end else begin
                            state <= LOAD;
                            load  <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt      <= '0;
                    state    <= SHIFT;
                    shift_en <= 1'b1;
                end
                SHIFT: begin
                    state    <= OP;
                    in_op    <= 1'b1;
                    count_en <= 1'b1;
                end
                OP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state  <= FIX;
                        in_fix <= 1'b1;
                    end else begin
                        state    <= SHIFT;
                        shift_en <= 1'b1;
                    end
                end
                FIX: begin
                    state <= DONE;
                    valid <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign add_en    = in_op & sign_r;
    assign sub_en    = in_op & ~sign_r;
    assign final_add = in_fix & sign_r;
    assign div_zero  = valid & divz;

endmodule

// File: tb/tb_divider_control_unit.sv
// Bench for divider_control_unit: behavioural non-restoring datapath drives sign_r,
// a scoreboard queue holds expected valid timing/results checked by a monitor.
module tb_divider_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] divisor;
    logic       sign_r;
    logic       load, shift_en, add_en, sub_en, final_add, count_en;
    logic       busy, valid, div_zero;

    always #5 clk = ~clk;

    divider_control_unit #(.ITERATIONS(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .divisor(divisor), .sign_r(sign_r),
        .load(load), .shift_en(shift_en), .add_en(add_en), .sub_en(sub_en),
        .final_add(final_add), .count_en(count_en), .busy(busy), .valid(valid),
        .div_zero(div_zero)
    );

    // Behavioural datapath: 10-bit signed partial remainder so 2*R never overflows.
    logic [9:0] acc  = '0;
    logic [7:0] quo  = '0;
    logic [7:0] mreg = '0;
    logic [7:0] dividend;
    logic       force_en, force_val;

    assign sign_r = force_en ? force_val : acc[9];

    always @(posedge clk) begin : model
        logic [9:0] t;
        if (load) begin
            acc  <= '0;
            quo  <= dividend;
            mreg <= divisor;
        end else if (shift_en) begin
            acc <= {acc[8:0], quo[7]};
            quo <= {quo[6:0], 1'b0};
        end else if (add_en || sub_en) begin
            t = add_en ? acc + {2'b00, mreg} : acc - {2'b00, mreg};
            acc    <= t;
            quo[0] <= ~t[9];
        end else if (final_add) begin
            acc <= acc + {2'b00, mreg};
        end
    end

    typedef struct {
        int         e0;
        int         exp_cyc;
        bit         dz;
        bit         chk;
        logic [7:0] q;
        logic [7:0] r;
        int         nl;
        int         nsh;
        int         nop;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nvalid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({load, shift_en, add_en, sub_en, final_add, count_en, busy, valid, div_zero});
    endfunction

    // Phase classes: 0 idle, 1 load, 2 shift, 3 op, 4 fix, 5 done.
    function automatic bit legal(input int p, input int c);
        case (p)
            0: return c == 0 || c == 1 || c == 5;
            1: return c == 2;
            2: return c == 3;
            3: return c == 2 || c == 4;
            4: return c == 5;
            5: return c == 0;
            default: return 1'b0;
        endcase
    endfunction

    int nl = 0, nsh = 0, nas = 0, ncnt = 0, nbusy = 0, viol = 0, prev_cl = 0;
    bit prev_rst = 1'b1;

    always @(posedge clk) begin : monitor
        int   cl;
        exp_t e;
        cyc++;
        #1;
        if (reset) begin
            nl = 0; nsh = 0; nas = 0; ncnt = 0; nbusy = 0; viol = 0;
            prev_cl = 0; prev_rst = 1'b1;
        end else begin
            if (!busy)          cl = 0;
            else if (valid)     cl = 5;
            else if (load)      cl = 1;
            else if (shift_en)  cl = 2;
            else if (count_en)  cl = 3;
            else                cl = 4;
            if (!prev_rst && !legal(prev_cl, cl)) viol++;
            if ($countones({load, shift_en, add_en, sub_en, final_add}) > 1) viol++;
            if (cl == 3 && (add_en !== sign_r || sub_en !== ~sign_r)) viol++;
            if (cl != 3 && (add_en || sub_en || count_en)) viol++;
            if (cl == 4 && final_add !== sign_r) viol++;
            if (cl != 4 && final_add) viol++;
            if (valid && !busy) viol++;
            if (div_zero && !valid) viol++;
            nl    += int'(load);
            nsh   += int'(shift_en);
            nas   += int'(add_en | sub_en);
            ncnt  += int'(count_en);
            nbusy += int'(busy);
            if (valid) begin
                nvalid++;
                check("sb_entry_for_valid", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("valid_cycle", cyc, e.exp_cyc);
                    check("div_zero", 32'(div_zero), 32'(e.dz));
                    if (e.chk) begin
                        check("quotient", 32'(quo), 32'(e.q));
                        check("remainder", 32'(acc[7:0]), 32'(e.r));
                    end
                    check("load_count", nl, e.nl);
                    check("shift_count", nsh, e.nsh);
                    check("addsub_count", nas, e.nop);
                    check("count_en_count", ncnt, e.nop);
                    check("busy_cycles", nbusy, e.exp_cyc - e.e0 + 1);
                    check("seq_violations", viol, 0);
                end
                nl = 0; nsh = 0; nas = 0; ncnt = 0; nbusy = 0; viol = 0;
            end
            prev_cl  = cl;
            prev_rst = 1'b0;
        end
    end

    function automatic exp_t make_exp(input int e0, input bit zero_path, input bit chk,
                                      input logic [7:0] q, input logic [7:0] r);
        exp_t e;
        e.e0  = e0;
        e.chk = chk;
        e.q   = q;
        e.r   = r;
        if (zero_path) begin
            e.exp_cyc = e0;
            e.dz = 1'b1; e.nl = 0; e.nsh = 0; e.nop = 0;
        end else begin
            e.exp_cyc = e0 + 18;
            e.dz = 1'b0; e.nl = 1; e.nsh = 8; e.nop = 8;
        end
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(busy), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Returns at the negedge inside cycle 1 of the new operation.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit chk,
                          input logic [7:0] q, input logic [7:0] r);
        bit zero_path;
`ifdef DIVCTRL_DIVZERO_EN
        zero_path = (b == 8'd0);
`else
        zero_path = 1'b0;
`endif
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(make_exp(cyc + 1, zero_path, chk, q, r));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic forced_sign(input logic v);
        int n;
        force_en  = 1'b1;
        force_val = v;
        launch(8'd50, 8'd9, 1'b0, 8'd0, 8'd0);
        n = 0;
        while (!count_en && n < 30) begin @(negedge clk); n++; end
        check("op_add_en", 32'(add_en), 32'(v));
        check("op_sub_en", 32'(sub_en), 32'(!v));
        n = 0;
        while (!(busy && !load && !shift_en && !count_en && !valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("fix_final_add", 32'(final_add), 32'(v));
        drain();
        force_en = 1'b0;
    endtask

    logic [7:0] va [9] = '{8'd100, 8'd255, 8'd13, 8'd0,  8'd200, 8'd7,   8'd250, 8'd128, 8'd255};
    logic [7:0] vb [9] = '{8'd7,   8'd16,  8'd13, 8'd5,  8'd1,   8'd100, 8'd3,   8'd128, 8'd200};
    logic [7:0] vq [9] = '{8'd14,  8'd15,  8'd1,  8'd0,  8'd200, 8'd0,   8'd83,  8'd1,   8'd1};
    logic [7:0] vr [9] = '{8'd2,   8'd15,  8'd0,  8'd0,  8'd0,   8'd7,   8'd1,   8'd0,   8'd55};

    initial begin
        int nv;
        int e0;
        reset = 1'b1; start = 1'b0; divisor = '0; dividend = '0;
        force_en = 1'b0; force_val = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            launch(va[i], vb[i], 1'b1, vq[i], vr[i]);
            drain();
        end

        launch(8'd37, 8'd0, 1'b0, 8'd0, 8'd0);
        drain();

        forced_sign(1'b1);
        forced_sign(1'b0);

        // Reset during cycle 10 discards the division.
        launch(8'd100, 8'd7, 1'b1, 8'd14, 8'd2);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("reset_mid_outputs", outs(), 0);
        reset = 1'b0;
        nv = nvalid;
        repeat (25) @(negedge clk);
        check("no_valid_after_reset", nvalid, nv);
        launch(8'd200, 8'd1, 1'b1, 8'd200, 8'd0);
        drain();

        // Start pulses in cycles 5 and 12 are ignored.
        nv = nvalid;
        launch(8'd250, 8'd3, 1'b1, 8'd83, 8'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (25) @(negedge clk);
        check("single_valid", nvalid - nv, 1);

        // Start held high for 40 cycles: two divisions, valids 20 cycles apart.
        wait_idle();
        nv       = nvalid;
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        e0       = cyc + 1;
        sb.push_back(make_exp(e0, 1'b0, 1'b1, 8'd14, 8'd2));
        sb.push_back(make_exp(e0 + 20, 1'b0, 1'b1, 8'd14, 8'd2));
        repeat (40) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (25) @(negedge clk);
        check("held_valid_count", nvalid - nv, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
